// File: rtl/control_map_pkg.sv
// Shared definitions for the multi-player control mapper: heading encoding,
// PS/2 prefix bytes, byte-parser state type and the keyset lookup helpers.
package control_map_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parser_state_t;

    typedef struct packed {
        logic hit;
        dir_t dir;
    } key_match_t;

    // Opposite heading: up<->down and right<->left differ only in bit 1.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    // Resolve a completed scan code against one player's keyset selection.
    // Unused keyset values fall back to keyset 1; keyset 4 is the only
    // one that lives on extended codes.
    function automatic key_match_t keyset_lookup(input logic [2:0] keyset,
                                                 input logic [7:0] code,
                                                 input logic       extended);
        key_match_t m;
        logic [7:0] up_c;
        logic [7:0] right_c;
        logic [7:0] down_c;
        logic [7:0] left_c;
        logic       want_ext;
        case (keyset)
            3'd2: begin
                up_c = 8'h2C; left_c = 8'h2B; down_c = 8'h34; right_c = 8'h33; want_ext = 1'b0;
            end
            3'd3: begin
                up_c = 8'h43; left_c = 8'h3B; down_c = 8'h42; right_c = 8'h4B; want_ext = 1'b0;
            end
            3'd4: begin
                up_c = 8'h75; left_c = 8'h6B; down_c = 8'h73; right_c = 8'h74; want_ext = 1'b1;
            end
            default: begin
                up_c = 8'h1D; left_c = 8'h1C; down_c = 8'h1B; right_c = 8'h23; want_ext = 1'b0;
            end
        endcase
        m.hit = 1'b0;
        m.dir = DIR_UP;
        if (extended == want_ext) begin
            if (code == up_c) begin
                m.hit = 1'b1; m.dir = DIR_UP;
            end else if (code == right_c) begin
                m.hit = 1'b1; m.dir = DIR_RIGHT;
            end else if (code == down_c) begin
                m.hit = 1'b1; m.dir = DIR_DOWN;
            end else if (code == left_c) begin
                m.hit = 1'b1; m.dir = DIR_LEFT;
            end else begin
                m.hit = 1'b0;
            end
        end else begin
            m.hit = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/scan_prefix_parser.sv
// PS/2 byte parser: tracks E0/F0 prefixes and flags the byte that completes
// a make or break code. The completion outputs are combinational on the
// final byte so that player state can update on the very next edge.
module scan_prefix_parser
    import control_map_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [7:0] code,
    output logic       extended,
    output logic       is_break,
    output logic       code_valid
);

    parser_state_t state_r;
    logic          is_prefix_s;

    // Decode completion of a code from the current state and incoming byte.
    always_comb begin
        code        = scan_code;
        extended    = 1'b0;
        is_break    = 1'b0;
        is_prefix_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                is_prefix_s = (scan_code == SC_EXT) || (scan_code == SC_BRK);
            end
            ST_EXT: begin
                extended    = 1'b1;
                is_prefix_s = (scan_code == SC_EXT) || (scan_code == SC_BRK);
            end
            ST_BRK: begin
                is_break = 1'b1;
            end
            ST_EXT_BRK: begin
                extended = 1'b1;
                is_break = 1'b1;
            end
            default: begin
                is_prefix_s = 1'b0;
            end
        endcase
        code_valid = scan_valid && !is_prefix_s;
    end

    // Prefix state machine; advances only on qualified bytes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else if (scan_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (scan_code == SC_EXT) begin
                        state_r <= ST_EXT;
                    end else if (scan_code == SC_BRK) begin
                        state_r <= ST_BRK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (scan_code == SC_EXT) begin
                        state_r <= ST_EXT;
                    end else if (scan_code == SC_BRK) begin
                        state_r <= ST_EXT_BRK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: rtl/control_mapping_multi_player.sv
// Maps PS/2 keyboard codes to per-player headings. Each player latches the
// last direction key pressed since the previous game tick and commits it on
// step, refusing reversals and no-op turns.
module control_mapping_multi_player
    import control_map_pkg::*;
#(
    parameter int NUM_PLAYERS = 2
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [7:0]               scan_code,
    input  logic                     scan_valid,
    input  logic [3*NUM_PLAYERS-1:0] keyset,
    input  logic                     step,
    output logic [2*NUM_PLAYERS-1:0] dir,
    output logic [NUM_PLAYERS-1:0]   dir_changed,
    output logic [4*NUM_PLAYERS-1:0] key_held
);

    logic [7:0] code_s;
    logic       extended_s;
    logic       is_break_s;
    logic       code_valid_s;

    scan_prefix_parser u_parser (
        .clock      (clock),
        .resetn     (resetn),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .code       (code_s),
        .extended   (extended_s),
        .is_break   (is_break_s),
        .code_valid (code_valid_s)
    );

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
        localparam dir_t RESET_DIR = (i % 2 == 0) ? DIR_RIGHT : DIR_LEFT;

        logic [2:0] ks_s;
        key_match_t match_s;
        logic       hit_s;
        logic       turn_ok_s;

        logic [2:0] ks_prev_r;
        logic [3:0] held_r;
        logic       pend_valid_r;
        dir_t       pend_dir_r;
        dir_t       dir_r;
        logic       chg_r;

        assign ks_s      = keyset[3*i +: 3];
        assign match_s   = keyset_lookup(ks_s, code_s, extended_s);
        assign hit_s     = code_valid_s && match_s.hit;
        assign turn_ok_s = pend_valid_r && (pend_dir_r != dir_r) &&
                           (pend_dir_r != reverse_dir(dir_r));

        // Per-player held keys, pending turn and committed heading.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                ks_prev_r    <= 3'd0;
                held_r       <= 4'b0000;
                pend_valid_r <= 1'b0;
                pend_dir_r   <= DIR_UP;
                dir_r        <= RESET_DIR;
                chg_r        <= 1'b0;
            end else begin
                ks_prev_r <= ks_s;
                if (step && turn_ok_s) begin
                    dir_r <= pend_dir_r;
                    chg_r <= 1'b1;
                end else begin
                    dir_r <= dir_r;
                    chg_r <= 1'b0;
                end
                if (ks_s != ks_prev_r) begin
                    // New key mapping: forget anything seen under the old one.
                    held_r       <= 4'b0000;
                    pend_valid_r <= 1'b0;
                end else begin
                    if (hit_s) begin
                        held_r[match_s.dir] <= !is_break_s;
                    end else begin
                        held_r <= held_r;
                    end
                    // A make arriving with step survives as the next pending turn.
                    if (hit_s && !is_break_s) begin
                        pend_valid_r <= 1'b1;
                        pend_dir_r   <= match_s.dir;
                    end else if (step) begin
                        pend_valid_r <= 1'b0;
                    end else begin
                        pend_valid_r <= pend_valid_r;
                    end
                end
            end
        end

        assign dir[2*i +: 2]      = dir_r;
        assign dir_changed[i]     = chg_r;
        assign key_held[4*i +: 4] = held_r;
    end

endmodule

// File: tb/tb_control_mapping_multi_player.sv
// Directed bench for control_mapping_multi_player with two players.
module tb_control_mapping_multi_player;

    logic       clock;
    logic       resetn;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [5:0] keyset;
    logic       step;
    logic [3:0] dir;
    logic [1:0] dir_changed;
    logic [7:0] key_held;

    int checks;
    int fails;

    control_mapping_multi_player #(.NUM_PLAYERS(2)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .keyset      (keyset),
        .step        (step),
        .dir         (dir),
        .dir_changed (dir_changed),
        .key_held    (key_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clock);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic do_step();
        @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
    endtask

    task automatic set_keysets(input logic [2:0] k1, input logic [2:0] k0);
        @(negedge clock);
        keyset = {k1, k0};
        idle_cycles(3);
    endtask

    task automatic test_reset();
        @(negedge clock);
        resetn = 1'b0;
        idle_cycles(2);
        checks++;
        if (dir !== 4'b1101) begin
            fails++; $display("FAIL reset_dir: got %b expected %b", dir, 4'b1101);
        end
        checks++;
        if (key_held !== 8'h00 || dir_changed !== 2'b00) begin
            fails++; $display("FAIL reset_flags: got held=%h chg=%b expected 00/00", key_held, dir_changed);
        end
        resetn = 1'b1;
        idle_cycles(3);
    endtask

    task automatic test_reverse();
        send_byte(8'h1C);
        checks++;
        if (key_held[3:0] !== 4'b1000) begin
            fails++; $display("FAIL rev_held_left: got %b expected %b", key_held[3:0], 4'b1000);
        end
        do_step();
        checks++;
        if (dir[1:0] !== 2'd1 || dir_changed !== 2'b00) begin
            fails++; $display("FAIL rev_blocked: got dir0=%0d chg=%b expected 1/00", dir[1:0], dir_changed);
        end
        send_byte(8'h1D);
        do_step();
        checks++;
        if (dir[1:0] !== 2'd0 || dir_changed !== 2'b01) begin
            fails++; $display("FAIL rev_turn_up: got dir0=%0d chg=%b expected 0/01", dir[1:0], dir_changed);
        end
        @(negedge clock);
        checks++;
        if (dir_changed !== 2'b00) begin
            fails++; $display("FAIL rev_pulse_once: got %b expected 00", dir_changed);
        end
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1D);
        checks++;
        if (key_held[3:0] !== 4'b0000 || dir[1:0] !== 2'd0) begin
            fails++; $display("FAIL rev_break: got held=%b dir0=%0d expected 0000/0", key_held[3:0], dir[1:0]);
        end
    endtask

    task automatic test_extended();
        send_byte(8'hE0); send_byte(8'h74);
        checks++;
        if (key_held !== 8'h20) begin
            fails++; $display("FAIL ext_held_right: got %h expected %h", key_held, 8'h20);
        end
        do_step();
        checks++;
        if (dir !== 4'b1100 || dir_changed !== 2'b00) begin
            fails++; $display("FAIL ext_reverse: got dir=%b chg=%b expected 1100/00", dir, dir_changed);
        end
        send_byte(8'hE0); send_byte(8'h75);
        do_step();
        checks++;
        if (dir !== 4'b0000 || dir_changed !== 2'b10) begin
            fails++; $display("FAIL ext_turn_up: got dir=%b chg=%b expected 0000/10", dir, dir_changed);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        checks++;
        if (key_held[7:4] !== 4'b0010 || dir[3:2] !== 2'd0) begin
            fails++; $display("FAIL ext_break: got held1=%b dir1=%0d expected 0010/0", key_held[7:4], dir[3:2]);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    endtask

    task automatic test_last_wins();
        set_keysets(3'd4, 3'd2);
        send_byte(8'h33);
        do_step();
        checks++;
        if (dir[1:0] !== 2'd1) begin
            fails++; $display("FAIL lw_setup_right: got %0d expected 1", dir[1:0]);
        end
        send_byte(8'h2C); send_byte(8'h34);
        checks++;
        if (key_held[3:0] !== 4'b0111) begin
            fails++; $display("FAIL lw_held: got %b expected %b", key_held[3:0], 4'b0111);
        end
        do_step();
        checks++;
        if (dir[1:0] !== 2'd2 || dir_changed !== 2'b01) begin
            fails++; $display("FAIL lw_last_wins: got dir0=%0d chg=%b expected 2/01", dir[1:0], dir_changed);
        end
        send_byte(8'h1D);
        do_step();
        checks++;
        if (key_held !== 8'h07 || dir !== 4'b0010) begin
            fails++; $display("FAIL lw_unmatched: got held=%h dir=%b expected 07/0010", key_held, dir);
        end
        set_keysets(3'd4, 3'd1);
        checks++;
        if (key_held[3:0] !== 4'b0000 || dir[1:0] !== 2'd2) begin
            fails++; $display("FAIL lw_keyset_clear: got held0=%b dir0=%0d expected 0000/2", key_held[3:0], dir[1:0]);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h23);
        do_step();
        @(negedge clock);
        scan_code  = 8'h1D;
        scan_valid = 1'b1;
        step       = 1'b1;
        @(negedge clock);
        scan_valid = 1'b0;
        step       = 1'b0;
        checks++;
        if (dir[1:0] !== 2'd1 || dir_changed !== 2'b00) begin
            fails++; $display("FAIL b2b_coincident: got dir0=%0d chg=%b expected 1/00", dir[1:0], dir_changed);
        end
        do_step();
        checks++;
        if (dir[1:0] !== 2'd0 || dir_changed !== 2'b01) begin
            fails++; $display("FAIL b2b_next_step: got dir0=%0d chg=%b expected 0/01", dir[1:0], dir_changed);
        end
    endtask

    task automatic test_shared_key();
        set_keysets(3'd3, 3'd3);
        send_byte(8'h3B);
        do_step();
        checks++;
        if (dir !== 4'b1111 || dir_changed !== 2'b11) begin
            fails++; $display("FAIL shared_left: got dir=%b chg=%b expected 1111/11", dir, dir_changed);
        end
        send_byte(8'h43);
        do_step();
        checks++;
        if (dir !== 4'b0000 || dir_changed !== 2'b11) begin
            fails++; $display("FAIL shared_up: got dir=%b chg=%b expected 0000/11", dir, dir_changed);
        end
        checks++;
        if (key_held !== 8'h99) begin
            fails++; $display("FAIL shared_held: got %h expected %h", key_held, 8'h99);
        end
    endtask

    task automatic test_reset_midseq();
        set_keysets(3'd4, 3'd1);
        send_byte(8'hF0);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        idle_cycles(3);
        send_byte(8'h1D);
        checks++;
        if (key_held[3:0] !== 4'b0001) begin
            fails++; $display("FAIL midrst_make: got %b expected %b", key_held[3:0], 4'b0001);
        end
        do_step();
        checks++;
        if (dir[1:0] !== 2'd0 || dir_changed !== 2'b01) begin
            fails++; $display("FAIL midrst_turn: got dir0=%0d chg=%b expected 0/01", dir[1:0], dir_changed);
        end
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        resetn     = 1'b0;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        step       = 1'b0;
        keyset     = {3'd4, 3'd1};
        test_reset();
        test_reverse();
        test_extended();
        test_last_wins();
        test_back_to_back();
        test_shared_key();
        test_reset_midseq();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
